wb_regfile: RTL and testbench

Writeback stage and general-purpose register file of the 5-stage MIPS pipeline, sitting directly downstream of the MEM/WB pipeline register. It selects the writeback value (ALU result, load-extended memory data, or link address PC+8) and commits it to a 32×32 register file. It also serves the two combinational read ports used by the decode stage. A retired-write counter is provided for performance/debug.

---
 rtl/wb_regfile_if.sv | 30 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the decode stage and wb_regfile.
interface wb_regfile_if;
  logic [4:0]  a3_w;
  logic [31:0] aluout_w;
  logic [31:0] dmdata_w;
  logic [31:0] pc_w;
  logic        memtoreg_w;
  logic        link_w;
  logic        regwrite_w;
  logic [2:0]  ldtype_w;
  logic [4:0]  a1_d;
  logic [4:0]  a2_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] wb_data;
  logic [4:0]  wb_a3;
  logic [31:0] wr_count;

  modport master (
    output a3_w, aluout_w, dmdata_w, pc_w, memtoreg_w, link_w, regwrite_w, ldtype_w,
    output a1_d, a2_d,
    input  rd1_d, rd2_d, wb_data, wb_a3, wr_count
  );

  modport slave (
    input  a3_w, aluout_w, dmdata_w, pc_w, memtoreg_w, link_w, regwrite_w, ldtype_w,
    input  a1_d, a2_d,
    output rd1_d, rd2_d, wb_data, wb_a3, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// MIPS writeback source select, 32x32 register file and committed-write counter.
// Define RF_BYPASS_EN to make the read ports see a same-cycle commit (write-through).
module wb_regfile (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  logic [31:0] r_regs [0:31];
  logic [31:0] r_wr_count;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wb_data;
  logic        w_commit;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  always_comb begin
    w_byte = bus.dmdata_w[7:0];
    case (bus.aluout_w[1:0])
      2'd1:    w_byte = bus.dmdata_w[15:8];
      2'd2:    w_byte = bus.dmdata_w[23:16];
      2'd3:    w_byte = bus.dmdata_w[31:24];
      default: w_byte = bus.dmdata_w[7:0];
    endcase
    w_half = bus.aluout_w[1] ? bus.dmdata_w[31:16] : bus.dmdata_w[15:0];
  end

  always_comb begin
    w_load = bus.dmdata_w;
    case (bus.ldtype_w)
      3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load = {24'd0, w_byte};
      3'b011:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {16'd0, w_half};
      default: w_load = bus.dmdata_w;
    endcase
  end

  always_comb begin
    w_wb_data = bus.aluout_w;
    if (bus.link_w)
      w_wb_data = bus.pc_w + 32'd8;
    else if (bus.memtoreg_w)
      w_wb_data = w_load;
  end

  assign w_commit = bus.regwrite_w && (bus.a3_w != 5'd0);

  // Entry 0 is reset like the rest and never written, so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_regs[bus.a3_w] <= w_wb_data;
      r_wr_count       <= r_wr_count + 32'd1;
    end
  end

  always_comb begin
    w_rd1 = r_regs[bus.a1_d];
    w_rd2 = r_regs[bus.a2_d];
`ifdef RF_BYPASS_EN
    if (w_commit && (bus.a1_d == bus.a3_w)) w_rd1 = w_wb_data;
    if (w_commit && (bus.a2_d == bus.a3_w)) w_rd2 = w_wb_data;
`else
    // Decode sees stored contents only; the hazard unit forwards from wb_data/wb_a3.
`endif
    if (bus.a1_d == 5'd0) w_rd1 = '0;
    if (bus.a2_d == 5'd0) w_rd2 = '0;
  end

  assign bus.rd1_d    = w_rd1;
  assign bus.rd2_d    = w_rd2;
  assign bus.wb_data  = w_wb_data;
  assign bus.wb_a3    = w_commit ? bus.a3_w : 5'd0;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, source select, load extension, link, bypass, counter wrap.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  wb_regfile_if u_if ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    u_if.regwrite_w = 1'b0;
    u_if.memtoreg_w = 1'b0;
    u_if.link_w     = 1'b0;
    u_if.ldtype_w   = 3'b000;
  endtask

  task automatic drive_alu(input logic [4:0] a3, input logic [31:0] val);
    idle();
    u_if.a3_w       = a3;
    u_if.aluout_w   = val;
    u_if.regwrite_w = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    u_if.a3_w     = '0;
    u_if.aluout_w = '0;
    u_if.dmdata_w = '0;
    u_if.pc_w     = '0;
    u_if.a1_d     = 5'd5;
    u_if.a2_d     = 5'd0;
    #1;
    check("reset_rd1", u_if.rd1_d, 32'h0);
    check("reset_cnt", u_if.wr_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write $5 then pulse reset between edges
    drive_alu(5'd5, 32'h1234_5678);
    @(posedge clk); @(negedge clk);
    check("w5_rd1", u_if.rd1_d, 32'h1234_5678);
    check("w5_cnt", u_if.wr_count, 32'd1);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd1", u_if.rd1_d, 32'h0);
    check("async_rst_cnt", u_if.wr_count, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // ALU writeback to $8 and an attempted write to $0
    drive_alu(5'd8, 32'hDEAD_BEEF);
    u_if.a1_d = 5'd8;
    #1;
    check("alu_wb_data", u_if.wb_data, 32'hDEAD_BEEF);
    check("alu_wb_a3", {27'd0, u_if.wb_a3}, 32'd8);
    @(posedge clk); @(negedge clk);
    check("alu_rd1_8", u_if.rd1_d, 32'hDEAD_BEEF);
    check("alu_cnt", u_if.wr_count, 32'd1);
    drive_alu(5'd0, 32'h0000_0055);
    u_if.a1_d = 5'd0;
    #1;
    check("r0_wb_a3", {27'd0, u_if.wb_a3}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("r0_rd1", u_if.rd1_d, 32'h0);
    check("r0_cnt", u_if.wr_count, 32'd1);

    // Load extension on dmdata 0x80FF7F01
    idle();
    u_if.memtoreg_w = 1'b1;
    u_if.dmdata_w   = 32'h80FF_7F01;
    u_if.ldtype_w = 3'b001; u_if.aluout_w = 32'h0000_1003; #1;
    check("lb_off3", u_if.wb_data, 32'hFFFF_FF80);
    u_if.ldtype_w = 3'b010; u_if.aluout_w = 32'h0000_1001; #1;
    check("lbu_off1", u_if.wb_data, 32'h0000_007F);
    u_if.ldtype_w = 3'b001; u_if.aluout_w = 32'h0000_1002; #1;
    check("lb_off2", u_if.wb_data, 32'hFFFF_FFFF);
    u_if.ldtype_w = 3'b011; u_if.aluout_w = 32'h0000_1003; #1;
    check("lh_hi", u_if.wb_data, 32'hFFFF_80FF);
    u_if.ldtype_w = 3'b100; u_if.aluout_w = 32'h0000_1001; #1;
    check("lhu_lo", u_if.wb_data, 32'h0000_7F01);
    u_if.ldtype_w = 3'b000; #1;
    check("lw", u_if.wb_data, 32'h80FF_7F01);
    u_if.ldtype_w = 3'b111; #1;
    check("ld_other_lw", u_if.wb_data, 32'h80FF_7F01);
    u_if.memtoreg_w = 1'b0; u_if.ldtype_w = 3'b001; u_if.aluout_w = 32'h80FF_7F03; #1;
    check("ldtype_ignored", u_if.wb_data, 32'h80FF_7F03);

    // Commit an lb into $10
    u_if.memtoreg_w = 1'b1; u_if.ldtype_w = 3'b001; u_if.aluout_w = 32'h0000_0003;
    u_if.a3_w = 5'd10; u_if.regwrite_w = 1'b1; u_if.a2_d = 5'd10;
    @(posedge clk); @(negedge clk);
    check("lb_commit_rd2", u_if.rd2_d, 32'hFFFF_FF80);
    check("lb_commit_cnt", u_if.wr_count, 32'd2);

    // Link beats memtoreg
    idle();
    u_if.link_w = 1'b1; u_if.memtoreg_w = 1'b1; u_if.ldtype_w = 3'b001;
    u_if.pc_w = 32'h0000_3000; u_if.a3_w = 5'd31; u_if.regwrite_w = 1'b1; u_if.a2_d = 5'd31;
    #1;
    check("link_wb_data", u_if.wb_data, 32'h0000_3008);
    @(posedge clk); @(negedge clk);
    check("link_rd2", u_if.rd2_d, 32'h0000_3008);
    u_if.pc_w = 32'hFFFF_FFFC;
    #1;
    check("link_wrap_data", u_if.wb_data, 32'h0000_0004);
    @(posedge clk); @(negedge clk);
    check("link_wrap_rd2", u_if.rd2_d, 32'h0000_0004);
    check("link_cnt", u_if.wr_count, 32'd4);

    // Same-cycle write/read of $9
    drive_alu(5'd9, 32'h0000_0001);
    @(posedge clk); @(negedge clk);
    u_if.a1_d = 5'd9; u_if.a2_d = 5'd9;
    drive_alu(5'd9, 32'h0000_0002);
    #1;
`ifdef RF_BYPASS_EN
    check("byp_rd1_pre", u_if.rd1_d, 32'h0000_0002);
    check("byp_rd2_pre", u_if.rd2_d, 32'h0000_0002);
`else
    check("byp_rd1_pre", u_if.rd1_d, 32'h0000_0001);
    check("byp_rd2_pre", u_if.rd2_d, 32'h0000_0001);
`endif
    @(posedge clk); @(negedge clk);
    idle();
    u_if.aluout_w = 32'h0000_0003;
    #1;
    check("byp_rd1_post", u_if.rd1_d, 32'h0000_0002);
    check("byp_rd2_post", u_if.rd2_d, 32'h0000_0002);
    check("byp_cnt", u_if.wr_count, 32'd6);

    // Counter wrap
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1 release dut.r_wr_count;
    #1;
    check("wrap_preload", u_if.wr_count, 32'hFFFF_FFFF);
    drive_alu(5'd12, 32'h0000_00AA);
    @(posedge clk); @(negedge clk);
    check("wrap_cnt", u_if.wr_count, 32'h0);

    // Write presented during reset is lost; first commit after release lands
    rst_n = 1'b0;
    drive_alu(5'd13, 32'h0000_0BAD);
    u_if.a1_d = 5'd13;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_lost_rd1", u_if.rd1_d, 32'h0);
    check("rst_lost_cnt", u_if.wr_count, 32'h0);
    @(posedge clk); @(negedge clk);
    check("post_rst_rd1", u_if.rd1_d, 32'h0000_0BAD);
    check("post_rst_cnt", u_if.wr_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
